// File: rtl/dependence_eval_pipe.sv
// Two-stage valid/ready pipeline evaluating a selectable 3-input bitwise function,
// with per-result popcount and a saturating count of nonzero delivered results.
module dependence_eval_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  localparam int PW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [PW-1:0]    out_popcnt,
  output logic [1:0]       out_mode,
  output logic [CNT_W-1:0] hit_cnt,
  input  logic             cnt_clr
);

  logic             s1_v, s2_v;
  logic [WIDTH-1:0] s1_res, s2_res;
  logic [1:0]       s1_mode, s2_mode;
  logic [PW-1:0]    s2_pc;
  logic [WIDTH-1:0] fn_res;
  logic [PW-1:0]    s1_pc;
  logic             s1_ld, s2_ld, accept;

  assign s2_ld    = !s2_v || out_ready;
  assign s1_ld    = !s1_v || s2_ld;
  assign in_ready = s1_ld;
  assign accept   = in_valid && in_ready;

  always_comb begin
    fn_res = '0;
    case (in_mode)
      2'd0:    fn_res = in_a & (in_b | in_c);
      2'd1:    fn_res = (in_a & in_b) | (in_b & in_c) | (in_a & in_c);
      2'd2:    fn_res = in_a ^ in_b ^ in_c;
      default: fn_res = ~(in_a & (in_b | in_c));
    endcase
  end

  always_comb begin
    s1_pc = '0;
    for (int i = 0; i < WIDTH; i++) s1_pc = s1_pc + PW'(s1_res[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_res  <= '0;
      s1_mode <= '0;
    end else begin
      if (s1_ld) s1_v <= in_valid;
      if (accept) begin
        s1_res  <= fn_res;
        s1_mode <= in_mode;
      end
    end
  end

  // popcount is taken off the stage-1 register so the output stage stays a plain register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      s2_res  <= '0;
      s2_mode <= '0;
      s2_pc   <= '0;
    end else if (s2_ld) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_res  <= s1_res;
        s2_mode <= s1_mode;
        s2_pc   <= s1_pc;
      end
    end
  end

  assign out_valid  = s2_v;
  assign out_result = s2_res;
  assign out_popcnt = s2_pc;
  assign out_mode   = s2_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if (cnt_clr) begin
      hit_cnt <= '0;
    end else if (out_valid && out_ready && (out_result != '0) && !(&hit_cnt)) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dependence_eval_pipe.sv
// Bench for dependence_eval_pipe: directed and random streams checked against a
// queue-based reference model of occupancy, latency, ordering and hit counting.
module tb_dependence_eval_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, cnt_clr;
  logic [7:0] in_a, in_b, in_c;
  logic [1:0] in_mode;
  logic       in_ready, out_valid;
  logic [7:0] out_result;
  logic [3:0] out_popcnt;
  logic [1:0] out_mode;
  logic [15:0] hit_cnt;

  logic       c4_in_ready, c4_out_valid;
  logic [7:0] c4_out_result;
  logic [3:0] c4_out_popcnt;
  logic [1:0] c4_out_mode;
  logic [3:0] c4_hit;

  always #5 clk = ~clk;

  dependence_eval_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_popcnt(out_popcnt), .out_mode(out_mode), .hit_cnt(hit_cnt), .cnt_clr(cnt_clr)
  );

  dependence_eval_pipe #(.WIDTH(8), .CNT_W(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c4_in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_mode(in_mode),
    .out_valid(c4_out_valid), .out_ready(out_ready), .out_result(c4_out_result),
    .out_popcnt(c4_out_popcnt), .out_mode(c4_out_mode), .hit_cnt(c4_hit), .cnt_clr(cnt_clr)
  );

  typedef struct {
    logic [7:0] r;
    logic [1:0] m;
    int         c;
  } item_t;

  item_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_pop = -10;
  int hm16 = 0;
  int hm4 = 0;

  function automatic logic [7:0] ref_fn(input logic [7:0] a, b, c, input logic [1:0] m);
    case (m)
      2'd0:    return a & (b | c);
      2'd1:    return (a & b) | (b & c) | (a & c);
      2'd2:    return a ^ b ^ c;
      default: return ~(a & (b | c));
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive at negedge, check settled outputs, advance the model
  task automatic step(input logic v, input logic [7:0] a, b, c, input logic [1:0] m,
                      input logic ordy, input logic clr, output logic acc);
    logic  exp_ir, exp_ov;
    item_t it;
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_c = c; in_mode = m;
    out_ready = ordy; cnt_clr = clr;
    #1;
    chk("hit_cnt16", hit_cnt, hm16);
    chk("hit_cnt4", c4_hit, hm4);
    exp_ir = (q.size() < 2) || ordy;
    exp_ov = (q.size() > 0) && (cyc >= q[0].c + 2) && (cyc >= last_pop + 1);
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("out_result", out_result, q[0].r);
      chk("out_popcnt", out_popcnt, $countones(q[0].r));
      chk("out_mode", out_mode, q[0].m);
    end
    if (exp_ov && ordy) begin
      it = q.pop_front();
      last_pop = cyc;
      if (!clr && it.r != 8'h00) begin
        if (hm16 < 65535) hm16++;
        if (hm4 < 15) hm4++;
      end
    end
    if (clr) begin
      hm16 = 0;
      hm4 = 0;
    end
    acc = v && exp_ir;
    if (acc) q.push_back('{r: ref_fn(a, b, c, m), m: m, c: cyc});
    cyc++;
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 20 && q.size() > 0; k++) step(1'b0, 8'h0, 8'h0, 8'h0, 2'd0, 1'b1, 1'b0, acc);
    chk("drain_done", q.size(), 0);
  endtask

  initial begin
    logic acc;
    int   sent;
    logic [7:0] ra;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_mode = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_popcnt", out_popcnt, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // four modes on the classic operand set
    for (int m = 0; m < 4; m++) step(1'b1, 8'hF0, 8'hCC, 8'hAA, 2'(m), 1'b1, 1'b0, acc);
    drain();

    // stall with 5 beats offered: only 2 fit, then drain in order
    sent = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 1'b0, 1'b0, acc);
      if (acc) sent++;
    end
    chk("stall_accepts", sent, 2);
    for (int k = 0; k < 20 && sent < 5; k++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 1'b1, 1'b0, acc);
      if (acc) sent++;
    end
    chk("stall_sent", sent, 5);
    drain();

    // out_ready toggling each cycle across a 10-beat stream
    sent = 0;
    for (int k = 0; k < 60 && (sent < 10 || q.size() > 0); k++) begin
      step(sent < 10, 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
           (k % 2) == 0, 1'b0, acc);
      if (acc) sent++;
    end
    chk("toggle_sent", sent, 10);
    chk("toggle_empty", q.size(), 0);

    // random traffic with occasional clears
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, acc);
    drain();

    // saturation of the 4-bit counter, zero results, clear-vs-hit
    step(1'b0, 8'h0, 8'h0, 8'h0, 2'd0, 1'b1, 1'b1, acc);
    for (int k = 0; k < 17; k++) begin
      ra = 8'($urandom_range(1, 255));
      step(1'b1, ra, 8'h00, 8'h00, 2'd2, 1'b1, 1'b0, acc);
    end
    drain();
    for (int k = 0; k < 5; k++) step(1'b1, 8'h00, 8'($urandom), 8'($urandom), 2'd0, 1'b1, 1'b0, acc);
    drain();
    step(1'b1, 8'hFF, 8'hFF, 8'h00, 2'd0, 1'b1, 1'b0, acc);
    step(1'b0, 8'h0, 8'h0, 8'h0, 2'd0, 1'b1, 1'b0, acc);
    step(1'b0, 8'h0, 8'h0, 8'h0, 2'd0, 1'b1, 1'b1, acc);
    drain();

    // reset with two beats in flight
    for (int k = 0; k < 3; k++) step(1'b1, 8'hFF, 8'h0F, 8'h00, 2'd0, 1'b1, 1'b0, acc);
    drain();
    step(1'b1, 8'h3C, 8'hFF, 8'h00, 2'd1, 1'b0, 1'b0, acc);
    step(1'b1, 8'hC3, 8'hFF, 8'h00, 2'd1, 1'b0, 1'b0, acc);
    step(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, acc);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_result", out_result, 0);
    chk("midrst_hit_cnt16", hit_cnt, 0);
    chk("midrst_hit_cnt4", c4_hit, 0);
    q.delete();
    hm16 = 0;
    hm4 = 0;
    last_pop = -10;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step(1'b0, 8'h0, 8'h0, 8'h0, 2'd0, 1'b0, 1'b0, acc);
    step(1'b1, 8'hF0, 8'hCC, 8'hAA, 2'd3, 1'b1, 1'b0, acc);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
